// File: rtl/fir_frame_ctrl.sv
// ----------------------------------------------------------------------------
// fir_frame_ctrl
//
// Frame sequencer wrapped around an external 4-bit-in / 16-bit-out FIR.
// One frame is handled in the following order:
//   1. Collect FRAME_LEN samples from the input stream into a local buffer.
//   2. Wait until the output FIFO has room for every output of the frame.
//   3. Play the buffered samples into the FIR on consecutive cycles.
//   4. Play TAPS-1 zero samples into the FIR to flush it.
// Every FIR output of the frame is captured into a first-word-fall-through
// FIFO. The final output of the frame is tagged with m_last. The FIR delay
// line is cleared between frames, so each frame is an independent full
// convolution of FRAME_LEN+TAPS-1 outputs.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   s_valid  in   input sample valid
//   s_ready  out  sample accepted this cycle (high only while filling)
//   s_data   in   signed 4-bit input sample
//   fir_in   out  signed 4-bit sample to the FIR (zero outside the run phase)
//   fir_rst  out  FIR delay-line clear
//   fir_out  in   signed 16-bit FIR result
//   m_valid  out  output FIFO not empty
//   m_ready  in   downstream accepts the FIFO head
//   m_data   out  signed 16-bit filtered sample at the FIFO head
//   m_last   out  FIFO head is the final output of its frame
//   busy     out  controller is not in the fill phase
// ----------------------------------------------------------------------------

// Safety checker for the output FIFO. It is kept apart from the datapath.
module fir_frame_ctrl_checker #(
    parameter int OFIFO_DEPTH = 32,
    parameter int OCC_W       = 6
) (
    input logic             clk,
    input logic             rst,
    input logic             push_i,
    input logic             pop_i,
    input logic [OCC_W-1:0] occ_i
);

    // A push into a full FIFO without a simultaneous pop would lose data.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !pop_i && (occ_i == OCC_W'(OFIFO_DEPTH))));

    // The occupancy count must never exceed the physical depth.
    a_occ_bound: assert property (@(posedge clk) disable iff (rst)
        (occ_i <= OCC_W'(OFIFO_DEPTH)));

endmodule

module fir_frame_ctrl #(
    parameter int FRAME_LEN   = 16,  // input samples per frame (>= 1)
    parameter int TAPS        = 4,   // FIR taps; flush length is TAPS-1
    parameter int FIR_LATENCY = 1,   // fir_in -> fir_out latency (>= 0)
    parameter int OFIFO_DEPTH = 32   // must be >= FRAME_LEN+TAPS-1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [3:0]  s_data,
    output logic signed [3:0]  fir_in,
    output logic               fir_rst,
    input  logic signed [15:0] fir_out,
    output logic               m_valid,
    input  logic               m_ready,
    output logic signed [15:0] m_data,
    output logic               m_last,
    output logic               busy
);

    // Outputs produced by one frame.
    localparam int NEED     = FRAME_LEN + TAPS - 1;
    // A single counter serves both the fill/run phase and the flush phase.
    localparam int CNT_MAX  = (FRAME_LEN > TAPS) ? FRAME_LEN : TAPS;
    localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W    = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int OCC_W    = $clog2(OFIFO_DEPTH) + 1;
    // Highest occupancy that still leaves room for a whole frame.
    localparam int ROOM_MAX = OFIFO_DEPTH - NEED;
    localparam int FLUSH_LAST_I = (TAPS > 1) ? (TAPS - 2) : 0;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_LAST_I);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_FILL  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DRAIN = 3'd5
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [3:0]       fir_in_q;
    logic                    s_ready_q;
    logic                    busy_q;
    logic signed [3:0]       ibuf_q [FRAME_LEN];

    logic [IDX_W-1:0]        fill_idx_s;
    logic [IDX_W-1:0]        run_next_idx_s;
    logic                    accept_s;
    logic                    room_s;
    logic                    drv_valid_s;
    logic                    drv_last_s;
    logic                    cap_valid_s;
    logic                    cap_last_s;
    logic                    pipe_busy_s;

    // Output FIFO state.
    logic [16:0]             mem_q [OFIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    push_s;
    logic                    pop_s;
    logic [16:0]             head_s;

    // Pointer advance with wrap at the FIFO depth. The depth does not have to
    // be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OFIFO_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign fill_idx_s     = IDX_W'(cnt_q);
    assign run_next_idx_s = IDX_W'(cnt_q + CNT_W'(1));
    assign accept_s       = (state_q == ST_FILL) && s_valid && s_ready_q;
    // Uses registered occupancy, so entries popped this cycle count from the next cycle.
    assign room_s         = (occ_q <= OCC_W'(ROOM_MAX));

    // Frame sequencer: state, shared counter and the registered stream/FIR outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            fir_in_q  <= 4'sd0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    state_q   <= ST_FILL;
                    cnt_q     <= '0;
                    fir_in_q  <= 4'sd0;
                    s_ready_q <= 1'b1;
                    busy_q    <= 1'b0;
                end
                ST_FILL: begin
                    if (accept_s) begin
                        if (cnt_q == LAST_SAMPLE) begin
                            state_q   <= ST_WAIT;
                            cnt_q     <= '0;
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // Only start when every output of the frame is guaranteed
                    // a FIFO slot. The FIR can then never be stalled mid-frame.
                    if (room_s) begin
                        state_q  <= ST_RUN;
                        cnt_q    <= '0;
                        fir_in_q <= ibuf_q[0];
                    end
                end
                ST_RUN: begin
                    // fir_in_q already holds ibuf[cnt_q]. Look one sample ahead.
                    if (cnt_q == LAST_SAMPLE) begin
                        cnt_q    <= '0;
                        fir_in_q <= 4'sd0;
                        state_q  <= (TAPS > 1) ? ST_FLUSH : ST_DRAIN;
                    end else begin
                        cnt_q    <= cnt_q + CNT_W'(1);
                        fir_in_q <= ibuf_q[run_next_idx_s];
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Outputs still in flight through the FIR latency must land
                    // in the FIFO before the delay line is cleared.
                    if (!pipe_busy_s) begin
                        state_q <= ST_CLEAR;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    cnt_q     <= '0;
                    fir_in_q  <= 4'sd0;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Sample buffer written during fill. Its contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            ibuf_q[fill_idx_s] <= s_data;
        end
    end

    // Drive-side tags: one valid per FIR input of the frame, last on the final one.
    always_comb begin
        drv_valid_s = (state_q == ST_RUN) || (state_q == ST_FLUSH);
        if (TAPS > 1) begin
            drv_last_s = (state_q == ST_FLUSH) && (cnt_q == FLUSH_LAST);
        end else begin
            drv_last_s = (state_q == ST_RUN) && (cnt_q == LAST_SAMPLE);
        end
    end

    // Capture pipe: align the drive tags with fir_out across the FIR latency.
    generate
        if (FIR_LATENCY == 0) begin : g_no_lat
            assign cap_valid_s = drv_valid_s;
            assign cap_last_s  = drv_last_s;
            assign pipe_busy_s = 1'b0;
        end else begin : g_lat
            logic [FIR_LATENCY-1:0] pipe_v_q;
            logic [FIR_LATENCY-1:0] pipe_l_q;

            // Shift register for the valid/last tags, cleared on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_v_q <= '0;
                    pipe_l_q <= '0;
                end else begin
                    pipe_v_q[0] <= drv_valid_s;
                    pipe_l_q[0] <= drv_last_s;
                    for (int i = 1; i < FIR_LATENCY; i++) begin
                        pipe_v_q[i] <= pipe_v_q[i-1];
                        pipe_l_q[i] <= pipe_l_q[i-1];
                    end
                end
            end

            assign cap_valid_s = pipe_v_q[FIR_LATENCY-1];
            assign cap_last_s  = pipe_l_q[FIR_LATENCY-1];
            assign pipe_busy_s = |pipe_v_q;
        end
    endgenerate

    assign push_s = cap_valid_s;
    assign pop_s  = (occ_q != OCC_W'(0)) && m_ready;

    // Next-state for FIFO pointers and occupancy. Push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // FIFO control registers. Reset discards any partially delivered frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // FIFO storage: the 16-bit FIR result is stored unchanged next to its last tag.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {fir_out, cap_last_s};
        end
    end

    // First-word-fall-through head. It is forced to zero when empty, so
    // uninitialised storage never reaches the port.
    assign head_s  = mem_q[rd_ptr_q];
    assign m_valid = (occ_q != OCC_W'(0));
    assign m_data  = m_valid ? head_s[16:1] : 16'sd0;
    assign m_last  = m_valid & head_s[0];

    assign s_ready = s_ready_q;
    assign busy    = busy_q;
    assign fir_in  = fir_in_q;
    assign fir_rst = rst | (state_q == ST_CLEAR);

    fir_frame_ctrl_checker #(
        .OFIFO_DEPTH (OFIFO_DEPTH),
        .OCC_W       (OCC_W)
    ) u_checker (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .occ_i  (occ_q)
    );

endmodule
